// File: rtl/register_file_if.sv
// Write-port and read-port bundle for register_file.
// master: decode/writeback side driving addresses and write data; slave: the register file.
interface register_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addrA;
  logic [ADDR_W-1:0] rd_addrB;
  logic [DATA_W-1:0] rd_dataA;
  logic [DATA_W-1:0] rd_dataB;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addrA, rd_addrB,
    input  rd_dataA, rd_dataB
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addrA, rd_addrB,
    output rd_dataA, rd_dataB
  );
endinterface

// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports, one synchronous write port.
// Optional REGFILE_R0_ZERO_EN hardwires entry 0 to zero.
module register_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic            elk,
  input  logic            nrst,
  register_file_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Per-entry address decode; an unknown enable or address never selects another entry.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (bus.wr_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (bus.wr_addr == ADDR_W'(i)) begin
          mem_d[i] = bus.wr_data;
        end
      end
    end
`ifdef REGFILE_R0_ZERO_EN
    mem_d[0] = '0;
`endif
  end

  // Reset clears every entry immediately and overrides a coincident write.
  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // No write bypass: reads see the stored value until the write edge.
  always_comb begin
`ifdef REGFILE_R0_ZERO_EN
    bus.rd_dataA = (bus.rd_addrA == '0) ? '0 : mem_q[bus.rd_addrA];
    bus.rd_dataB = (bus.rd_addrB == '0) ? '0 : mem_q[bus.rd_addrB];
`else
    bus.rd_dataA = mem_q[bus.rd_addrA];
    bus.rd_dataB = mem_q[bus.rd_addrB];
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: reference model plus an expected-value queue.
// Build with REGFILE_R0_ZERO_EN defined to exercise the hardwired entry 0.
module tb_register_file;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic elk;
  logic nrst;

  register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
    .elk  (elk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial elk = 1'b0;
  always #5 elk = ~elk;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  int unsigned n_checks;
  int unsigned n_fail;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
  endtask

  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
`ifdef REGFILE_R0_ZERO_EN
    if (a != '0) model[a] = d;
`else
    model[a] = d;
`endif
  endtask

  // Drive both read addresses, queue the model's answers, then compare after settling.
  task automatic read_check(input string tag, input logic [ADDR_W-1:0] a,
                            input logic [ADDR_W-1:0] b);
    logic [DATA_W-1:0] exp_v;
    bus.rd_addrA = a;
    bus.rd_addrB = b;
    exp_q.push_back(model[a]);
    exp_q.push_back(model[b]);
    #1;
    exp_v = exp_q.pop_front();
    check_eq({tag, "_A"}, bus.rd_dataA, exp_v);
    exp_v = exp_q.pop_front();
    check_eq({tag, "_B"}, bus.rd_dataB, exp_v);
  endtask

  // One write cycle: drive at negedge, model updates at the posedge, sample after it.
  task automatic do_write(input logic en, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    @(negedge elk);
    bus.wr_en   = en;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(posedge elk);
    if (en && nrst) model_write(a, d);
    #1;
    bus.wr_en = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [DATA_W-1:0] rd;
    n_checks     = 0;
    n_fail       = 0;
    nrst         = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_addrA = '0;
    bus.rd_addrB = '0;
    model_clear();

    // Reset state: every address reads 0 on both ports.
    #2;
    for (int i = 0; i < int'(DEPTH); i++) begin
      read_check("rst_clear", ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));
    end
    @(negedge elk);
    #2 nrst = 1'b1;
    for (int i = 0; i < int'(DEPTH); i += 7) begin
      read_check("rst_release", ADDR_W'(i), ADDR_W'(i + 3));
    end

    // Basic write/read on each port.
    do_write(1'b1, 5'd10, 32'd11425652);
    read_check("wr10", 5'd10, 5'd0);
    do_write(1'b1, 5'd11, 32'd11425653);
    read_check("wr11", 5'd10, 5'd11);

    // Write disable leaves the entry alone.
    do_write(1'b0, 5'd10, 32'hDEADBEEF);
    read_check("wr_dis", 5'd10, 5'd10);

    // Read-during-write: old value before the edge, new value after.
    do_write(1'b1, 5'd5, 32'h0000_5555);
    @(negedge elk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd5;
    bus.wr_data = 32'hA5A5_5A5A;
    read_check("rdw_pre", 5'd5, 5'd5);
    @(posedge elk);
    model_write(5'd5, 32'hA5A5_5A5A);
    #1;
    bus.wr_en = 1'b0;
    read_check("rdw_post", 5'd5, 5'd5);

    // Entry 0 behaviour.
    do_write(1'b1, 5'd0, 32'h1234_5678);
    read_check("r0", 5'd0, 5'd0);
`ifdef REGFILE_R0_ZERO_EN
    check_eq("r0_const", bus.rd_dataA, 32'h0);
`else
    check_eq("r0_const", bus.rd_dataA, 32'h1234_5678);
`endif

    // Randomised writes with mixed reads, including last entry.
    do_write(1'b1, 5'd31, 32'hFFFF_FFFF);
    read_check("wr31", 5'd31, 5'd30);
    for (int k = 0; k < 40; k++) begin
      ra = ADDR_W'($urandom_range(DEPTH - 1));
      rd = $urandom();
      do_write(($urandom_range(3) != 0), ra, rd);
      rb = ADDR_W'($urandom_range(DEPTH - 1));
      read_check("rand", ra, rb);
    end

    // Asynchronous reset after writes: clears without a clock edge.
    do_write(1'b1, 5'd10, 32'd11425652);
    do_write(1'b1, 5'd11, 32'd11425653);
    @(negedge elk);
    #2 nrst = 1'b0;
    model_clear();
    read_check("rst_async", 5'd10, 5'd11);
    #2 nrst = 1'b1;
    read_check("rst_async_rel", 5'd10, 5'd11);

    // Reset held across a write edge: the write is lost.
    @(negedge elk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd7;
    bus.wr_data = 32'hCAFE_F00D;
    #4 nrst = 1'b0;
    @(posedge elk);
    #1;
    bus.wr_en = 1'b0;
    #1 nrst = 1'b1;
    read_check("rst_wr_edge", 5'd7, 5'd7);

    // First write after release lands on the first edge.
    do_write(1'b1, 5'd7, 32'h0BAD_CAFE);
    read_check("post_rst_wr", 5'd7, 5'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
